l1_ahb_mtx_dec_param: RTL and testbench
=======================================

Name: l1_ahb_mtx_dec_param

Overview:
- Parametrised per-slave-interface decoder for the L1 AHB bus matrix.
- Maps each address-phase transfer to one of NUM_PORTS output stages, or to an internal default slave (unmapped addresses), and tracks the data-phase owner to steer responses back.
- Adds two features: a runtime remap that swaps regions 0 and 1, and a saturating unmapped-access counter for debug.

Parameters:
- NUM_PORTS, 4, number of output stages (1..8).
- PORT_W, 3, width of the port index; must satisfy 2**PORT_W > NUM_PORTS. Index value NUM_PORTS denotes the default slave.
- REGION_BASE, {NUM_PORTS{22'h0}}, packed per-port base address, decode_addr_dec[31:10] granularity.
- REGION_LIMIT, {NUM_PORTS{22'h3f}}, packed per-port inclusive limit, same granularity.
- CNT_W, 8, width of the unmapped-access counter.

Ports:
- HCLK  in  1  AHB clock.
- HRESETn  in  1  async active-low reset.
- HREADYS  in  1  transfer-done from the input stage.
- sel_dec  in  1  HSEL from the input stage.
- decode_addr_dec  in  22  HADDR[31:10].
- trans_dec  in  2  HTRANS.
- remap  in  1  when 1, regions 0 and 1 are swapped; sampled in the address phase only.
- cnt_clr  in  1  synchronous clear of the unmapped counter.
- active_in  in  NUM_PORTS  per-output-stage active.
- readyout_in  in  NUM_PORTS  per-port HREADYOUT.
- resp_in  in  2*NUM_PORTS  per-port HRESP.
- rdata_in  in  32*NUM_PORTS  per-port HRDATA.
- ruser_in  in  32*NUM_PORTS  per-port HRUSER.
- sel_out  out  NUM_PORTS  one-hot HSEL to the output stages.
- active_dec  out  1  active of the selected port.
- HREADYOUTS  out  1  muxed HREADYOUT.
- HRESPS  out  2  muxed HRESP.
- HRDATAS  out  32  muxed read data.
- HRUSERS  out  32  muxed read user data.
- unmapped_cnt  out  CNT_W  saturating count of unmapped NONSEQ/SEQ accesses.

Behaviour:
- Reset: HRESETn is asynchronous, active-low; clock is HCLK. All state clears while HRESETn is low:
  - data_port=0.
  - Default-slave FSM in IDLE.
  - unmapped_cnt=0.
- Combinational outputs are defined at reset as follows:
  - sel_out=0 unless sel_dec.
  - HREADYOUTS=readyout_in[0], HRESPS=resp_in[1:0], HRDATAS=rdata_in[31:0].
- Address decode (combinational):
  - Region i is hit when REGION_BASE[i] <= addr <= REGION_LIMIT[i]. If regions overlap, the lowest index wins.
  - When remap=1, the hit for region 0 selects port 1 and vice versa. Ignored when NUM_PORTS=1.
  - No hit selects the default slave, addr_port=NUM_PORTS.
  - Override: if trans_dec==IDLE, addr_port=data_port. This suppresses needless port switching.
- Select: sel_out[i] = sel_dec & (addr_port==i). sel_dft = sel_dec & (addr_port==NUM_PORTS).
- active_dec = active_in[addr_port], or 1 when the default slave is selected.
- Data phase:
  - data_port <= addr_port on every HCLK edge where HREADYS=1; holds otherwise.
  - HREADYOUTS, HRESPS, HRDATAS and HRUSERS are muxed by data_port.
  - When the default slave owns the data phase, HRDATAS and HRUSERS are 0.
  - Any data_port index outside 0..NUM_PORTS drives X on all muxed outputs (assertion target).
- Default-slave FSM, states IDLE, ERR1, ERR2:
  - IDLE: readyout=1, resp=OKAY. On sel_dft & HREADYS & trans_dec[1], go to ERR1.
  - ERR1: readyout=0, resp=ERROR(2'b01). Unconditionally go to ERR2.
  - ERR2: readyout=1, resp=ERROR.
    - If sel_dft & HREADYS & trans_dec[1], go to ERR1 (back-to-back error).
    - Otherwise go to IDLE.
  - IDLE or BUSY transfers to the default slave get a zero-wait OKAY.
- Counter:
  - Increments on each IDLE->ERR1 or ERR2->ERR1 transition.
  - Saturates at all-ones.
  - cnt_clr has priority over an increment in the same cycle; the result is 0.
- Reset mid-transfer: the FSM returns to IDLE and data_port to 0 immediately. No error response is completed.

Decomposition:
- Shared package l1_ahb_mtx_pkg holds:
  - HTRANS encodings: IDLE, BUSY, NONSEQ, SEQ.
  - HRESP encodings: OKAY, ERROR.
  - Default-slave state typedef.
- Sub-module l1_ahb_mtx_dft_slv_err contains the 3-state FSM. Its outputs are readyout, resp, and an err_start pulse that drives the counter.

Test Plan:
- Mapped NONSEQ to base of region 2, HREADYS=1: sel_out=4'b0100; the next cycle returns rdata_in[95:64] with HRESPS=OKAY.
- Unmapped address 22'h3fffff NONSEQ:
  - sel_out=0.
  - Cycle+1: HREADYOUTS=0, HRESPS=01.
  - Cycle+2: HREADYOUTS=1, HRESPS=01.
  - unmapped_cnt=1.
- remap=1, address in region 0: sel_out=4'b0010. With remap=0, the same address gives 4'b0001.
- IDLE transfer with data_port=3: sel_out=4'b1000, no port switch. IDLE to an unmapped address gives OKAY with zero wait.
- 256 back-to-back unmapped accesses with CNT_W=8: counter holds at 8'hff. cnt_clr asserted together with an error start gives 0.
- HRESETn asserted during ERR1:
  - FSM returns to IDLE.
  - HREADYOUTS reflects readyout_in[0] without waiting for a clock.
  - unmapped_cnt=0.

Source files
------------

// File: rtl/l1_ahb_mtx_pkg.sv
// Shared definitions for the L1 AHB bus matrix: transfer/response encodings,
// default-slave state type and the per-port data-phase response payload.
package l1_ahb_mtx_pkg;

  localparam int unsigned ADDR_W   = 22;  // HADDR[31:10]
  localparam int unsigned HTRANS_W = 2;
  localparam int unsigned HRESP_W  = 2;
  localparam int unsigned DATA_W   = 32;

  typedef enum logic [HTRANS_W-1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [HRESP_W-1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [1:0] {
    DFT_IDLE = 2'b00,
    DFT_ERR1 = 2'b01,
    DFT_ERR2 = 2'b10
  } dft_state_e;

  // Data-phase response from one output stage (or the default slave)
  typedef struct packed {
    logic               ready;
    logic [HRESP_W-1:0] resp;
    logic [DATA_W-1:0]  rdata;
    logic [DATA_W-1:0]  ruser;
  } slv_rsp_t;

endpackage

// File: rtl/l1_ahb_mtx_dft_slv_err.sv
// Default slave for unmapped addresses: answers NONSEQ/SEQ with a two-cycle
// ERROR response, IDLE/BUSY with a zero-wait OKAY.
// Ports:
//   HCLK, HRESETn  clock, async active-low reset
//   err_req        NONSEQ/SEQ to the default slave accepted this cycle
//   readyout       HREADYOUT of the default slave
//   resp           HRESP of the default slave
//   err_start      pulse when a new error response begins (drives the counter)
module l1_ahb_mtx_dft_slv_err
  import l1_ahb_mtx_pkg::*;
(
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               err_req,
  output logic               readyout,
  output logic [HRESP_W-1:0] resp,
  output logic               err_start
);

  dft_state_e state_q;
  dft_state_e state_d;

  // State register; readyout/resp are registered from the next state
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= DFT_IDLE;
      readyout <= 1'b1;
      resp     <= RESP_OKAY;
    end else begin
      state_q  <= state_d;
      readyout <= (state_d != DFT_ERR1);
      resp     <= (state_d == DFT_IDLE) ? RESP_OKAY : RESP_ERROR;
    end
  end

  // Next state; err_start flags IDLE->ERR1 and ERR2->ERR1
  always_comb begin
    state_d   = state_q;
    err_start = 1'b0;
    case (state_q)
      DFT_IDLE: begin
        if (err_req) begin
          state_d   = DFT_ERR1;
          err_start = 1'b1;
        end
      end
      DFT_ERR1: state_d = DFT_ERR2;
      DFT_ERR2: begin
        if (err_req) begin
          state_d   = DFT_ERR1;
          err_start = 1'b1;
        end else begin
          state_d = DFT_IDLE;
        end
      end
      default: state_d = DFT_IDLE;
    endcase
  end

endmodule

// File: rtl/l1_ahb_mtx_dec_param.sv
// Per-slave-interface address decoder for the L1 AHB bus matrix. Selects one
// of NUM_PORTS output stages (or the internal default slave), tracks the
// data-phase owner to steer responses back, supports swapping regions 0/1 and
// counts unmapped NONSEQ/SEQ accesses.
// Ports:
//   HCLK, HRESETn         clock, async active-low reset
//   HREADYS               transfer done on the input stage
//   sel_dec, decode_addr_dec, trans_dec   address phase from the input stage
//   remap                 swap regions 0 and 1 (address phase only)
//   cnt_clr               synchronous clear of unmapped_cnt
//   active_in, readyout_in, resp_in, rdata_in, ruser_in   per-port inputs
//   sel_out, active_dec   address-phase select / active of selected port
//   HREADYOUTS, HRESPS, HRDATAS, HRUSERS   data-phase response mux
//   unmapped_cnt          saturating unmapped-access counter
module l1_ahb_mtx_dec_param
  import l1_ahb_mtx_pkg::*;
#(
  parameter int unsigned                   NUM_PORTS    = 4,
  parameter int unsigned                   PORT_W       = 3,
  parameter logic [ADDR_W*NUM_PORTS-1:0]   REGION_BASE  = {NUM_PORTS{22'h0}},
  parameter logic [ADDR_W*NUM_PORTS-1:0]   REGION_LIMIT = {NUM_PORTS{22'h3f}},
  parameter int unsigned                   CNT_W        = 8
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic                           HREADYS,
  input  logic                           sel_dec,
  input  logic [ADDR_W-1:0]              decode_addr_dec,
  input  logic [HTRANS_W-1:0]            trans_dec,
  input  logic                           remap,
  input  logic                           cnt_clr,
  input  logic [NUM_PORTS-1:0]           active_in,
  input  logic [NUM_PORTS-1:0]           readyout_in,
  input  logic [HRESP_W*NUM_PORTS-1:0]   resp_in,
  input  logic [DATA_W*NUM_PORTS-1:0]    rdata_in,
  input  logic [DATA_W*NUM_PORTS-1:0]    ruser_in,
  output logic [NUM_PORTS-1:0]           sel_out,
  output logic                           active_dec,
  output logic                           HREADYOUTS,
  output logic [HRESP_W-1:0]             HRESPS,
  output logic [DATA_W-1:0]              HRDATAS,
  output logic [DATA_W-1:0]              HRUSERS,
  output logic [CNT_W-1:0]               unmapped_cnt
);

  localparam logic [PORT_W-1:0] DFT_PORT = PORT_W'(NUM_PORTS);

  logic [PORT_W-1:0]  hit_port;
  logic [PORT_W-1:0]  addr_port;
  logic [PORT_W-1:0]  data_port;
  logic               sel_dft;
  logic               err_req_c;
  logic               dft_readyout;
  logic [HRESP_W-1:0] dft_resp;
  logic               err_start;
  slv_rsp_t           rsp_mux;

  // Region decode: scan downward so the lowest matching index wins
  always_comb begin
    hit_port = DFT_PORT;
    for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
      if ((decode_addr_dec >= REGION_BASE[i*ADDR_W +: ADDR_W]) &&
          (decode_addr_dec <= REGION_LIMIT[i*ADDR_W +: ADDR_W])) begin
        hit_port = PORT_W'(i);
      end
    end
    if (remap && (NUM_PORTS > 1)) begin
      if (hit_port == PORT_W'(0))      hit_port = PORT_W'(1);
      else if (hit_port == PORT_W'(1)) hit_port = PORT_W'(0);
    end
  end

  // IDLE keeps the current owner so the output stage does not switch needlessly
  assign addr_port = (trans_dec == TRANS_IDLE) ? data_port : hit_port;

  // One-hot select and active of the addressed port
  always_comb begin
    sel_out    = '0;
    active_dec = 1'b1;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (addr_port == PORT_W'(i)) begin
        sel_out[i] = sel_dec;
        active_dec = active_in[i];
      end
    end
  end

  assign sel_dft   = sel_dec && (addr_port == DFT_PORT);
  assign err_req_c = sel_dft && HREADYS && trans_dec[1];

  // Data-phase owner
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      data_port <= '0;
    end else if (HREADYS) begin
      data_port <= addr_port;
    end
  end

  // Owner index beyond the default slave is unreachable by construction
  always_ff @(posedge HCLK) begin
    if (HRESETn) begin
      assert (data_port <= DFT_PORT);
    end
  end

  l1_ahb_mtx_dft_slv_err u_dft (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .err_req   (err_req_c),
    .readyout  (dft_readyout),
    .resp      (dft_resp),
    .err_start (err_start)
  );

  // Response mux; out-of-range owner drives X
  always_comb begin
    rsp_mux = 'x;
    if (data_port == DFT_PORT) begin
      rsp_mux = '{ready: dft_readyout, resp: dft_resp, rdata: '0, ruser: '0};
    end
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (data_port == PORT_W'(i)) begin
        rsp_mux = '{ready: readyout_in[i],
                    resp:  resp_in[i*HRESP_W +: HRESP_W],
                    rdata: rdata_in[i*DATA_W +: DATA_W],
                    ruser: ruser_in[i*DATA_W +: DATA_W]};
      end
    end
  end

  assign HREADYOUTS = rsp_mux.ready;
  assign HRESPS     = rsp_mux.resp;
  assign HRDATAS    = rsp_mux.rdata;
  assign HRUSERS    = rsp_mux.ruser;

  // Saturating unmapped-access counter; clear wins over increment
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      unmapped_cnt <= '0;
    end else if (cnt_clr) begin
      unmapped_cnt <= '0;
    end else if (err_start && (unmapped_cnt != '1)) begin
      unmapped_cnt <= unmapped_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_l1_ahb_mtx_dec_param.sv
// Bench for l1_ahb_mtx_dec_param: directed cases plus randomized traffic,
// all outputs checked every cycle against a behavioural model.
module tb_l1_ahb_mtx_dec_param;

  localparam int N  = 4;
  localparam int PW = 3;
  localparam int CW = 8;

  // Regions 2 and 3 overlap at 0xb0..0xbf; region 2 must win there
  localparam logic [22*N-1:0] BASE  = {22'h0b0, 22'h080, 22'h040, 22'h000};
  localparam logic [22*N-1:0] LIMIT = {22'h0ff, 22'h0bf, 22'h07f, 22'h03f};
  int unsigned base_a  [N] = '{32'h000, 32'h040, 32'h080, 32'h0b0};
  int unsigned limit_a [N] = '{32'h03f, 32'h07f, 32'h0bf, 32'h0ff};

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          HREADYS = 1'b0;
  logic          sel_dec = 1'b0;
  logic [21:0]   decode_addr_dec = '0;
  logic [1:0]    trans_dec = '0;
  logic          remap = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [N-1:0]  active_in = '0;
  logic [N-1:0]  readyout_in = '0;
  logic [2*N-1:0]  resp_in = '0;
  logic [32*N-1:0] rdata_in = '0;
  logic [32*N-1:0] ruser_in = '0;
  logic [N-1:0]  sel_out;
  logic          active_dec;
  logic          HREADYOUTS;
  logic [1:0]    HRESPS;
  logic [31:0]   HRDATAS;
  logic [31:0]   HRUSERS;
  logic [CW-1:0] unmapped_cnt;

  always #5 HCLK = ~HCLK;

  l1_ahb_mtx_dec_param #(
    .NUM_PORTS(N), .PORT_W(PW), .REGION_BASE(BASE), .REGION_LIMIT(LIMIT), .CNT_W(CW)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HREADYS(HREADYS), .sel_dec(sel_dec),
    .decode_addr_dec(decode_addr_dec), .trans_dec(trans_dec), .remap(remap),
    .cnt_clr(cnt_clr), .active_in(active_in), .readyout_in(readyout_in),
    .resp_in(resp_in), .rdata_in(rdata_in), .ruser_in(ruser_in),
    .sel_out(sel_out), .active_dec(active_dec), .HREADYOUTS(HREADYOUTS),
    .HRESPS(HRESPS), .HRDATAS(HRDATAS), .HRUSERS(HRUSERS), .unmapped_cnt(unmapped_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: data-phase owner, error-response step (0 none, 1 wait, 2 last), counter
  int m_dp  = 0;
  int m_ph  = 0;
  int m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_port();
    int p;
    if (trans_dec == 2'b00) return m_dp;
    p = N;
    for (int i = 0; i < N; i++) begin
      if (decode_addr_dec >= base_a[i] && decode_addr_dec <= limit_a[i]) begin
        p = i;
        break;
      end
    end
    if (remap && p < 2) p = 1 - p;
    return p;
  endfunction

  function automatic logic model_ready();
    return (m_dp == N) ? (m_ph != 1) : readyout_in[m_dp];
  endfunction

  task automatic check_all();
    int p;
    logic [31:0] e_sel;
    p = exp_port();
    e_sel = (sel_dec && p < N) ? (32'd1 << p) : 32'd0;
    chk("sel_out", 32'(sel_out), e_sel);
    chk("active_dec", 32'(active_dec), (p == N) ? 32'd1 : 32'(active_in[p]));
    chk("HREADYOUTS", 32'(HREADYOUTS), 32'(model_ready()));
    chk("HRESPS", 32'(HRESPS), (m_dp == N) ? ((m_ph != 0) ? 32'd1 : 32'd0) : 32'(resp_in[2*m_dp +: 2]));
    chk("HRDATAS", HRDATAS, (m_dp == N) ? 32'd0 : rdata_in[32*m_dp +: 32]);
    chk("HRUSERS", HRUSERS, (m_dp == N) ? 32'd0 : ruser_in[32*m_dp +: 32]);
    chk("unmapped_cnt", 32'(unmapped_cnt), 32'(m_cnt));
  endtask

  task automatic model_reset();
    m_dp = 0; m_ph = 0; m_cnt = 0;
  endtask

  // Advance the model by one clock using the inputs present at the edge
  task automatic model_update();
    int  p;
    bit  start;
    if (!HRESETn) begin
      model_reset();
      return;
    end
    p = exp_port();
    start = sel_dec && (p == N) && HREADYS && trans_dec[1];
    if (cnt_clr) m_cnt = 0;
    else if (start && m_ph != 1 && m_cnt < 255) m_cnt++;
    m_ph = (m_ph == 1) ? 2 : (start ? 1 : 0);
    if (HREADYS) m_dp = p;
  endtask

  task automatic settle();
    #1 check_all();
  endtask

  task automatic advance();
    @(posedge HCLK);
    model_update();
    @(negedge HCLK);
  endtask

  task automatic req(input logic s, input logic [21:0] a, input logic [1:0] t, input logic r);
    sel_dec = s; decode_addr_dec = a; trans_dec = t; HREADYS = r;
  endtask

  initial begin
    readyout_in = 4'b1010;
    for (int i = 0; i < N; i++) begin
      rdata_in[32*i +: 32] = 32'hA000_0000 | 32'(i);
      ruser_in[32*i +: 32] = 32'hB000_0000 | 32'(i);
    end
    active_in = 4'b0110;
    model_reset();
    @(negedge HCLK);
    @(negedge HCLK);
    // Reset state: owner port 0, no select
    settle();
    chk("rst_sel_out", 32'(sel_out), 32'd0);
    chk("rst_hready", 32'(HREADYOUTS), 32'd0);
    chk("rst_rdata", HRDATAS, 32'hA000_0000);
    HRESETn = 1'b1;
    readyout_in = 4'b1111;

    // Mapped NONSEQ to region 2 base, data returned next cycle
    req(1, 22'h080, 2'b10, 1); settle();
    chk("reg2_sel", 32'(sel_out), 32'h4);
    advance();
    req(1, 22'h000, 2'b00, 1); settle();
    chk("reg2_rdata", HRDATAS, 32'hA000_0002);
    chk("reg2_resp", 32'(HRESPS), 32'd0);
    advance();

    // Unmapped NONSEQ: two-cycle ERROR
    req(1, 22'h3fffff, 2'b10, 1); settle();
    chk("unm_sel", 32'(sel_out), 32'd0);
    advance();
    req(1, 22'h3fffff, 2'b00, 0); settle();
    chk("unm_c1_ready", 32'(HREADYOUTS), 32'd0);
    chk("unm_c1_resp", 32'(HRESPS), 32'd1);
    advance();
    req(1, 22'h3fffff, 2'b00, 1); settle();
    chk("unm_c2_ready", 32'(HREADYOUTS), 32'd1);
    chk("unm_c2_resp", 32'(HRESPS), 32'd1);
    chk("unm_cnt", 32'(unmapped_cnt), 32'd1);
    advance();

    // BUSY to the default slave: zero-wait OKAY
    req(1, 22'h3fffff, 2'b01, 1); settle(); advance();
    req(1, 22'h3fffff, 2'b00, 1); settle();
    chk("busy_ready", 32'(HREADYOUTS), 32'd1);
    chk("busy_resp", 32'(HRESPS), 32'd0);
    advance();

    // Remap swaps regions 0 and 1
    remap = 1'b1; req(1, 22'h010, 2'b10, 0); settle();
    chk("remap1_sel", 32'(sel_out), 32'h2);
    remap = 1'b0; settle();
    chk("remap0_sel", 32'(sel_out), 32'h1);
    advance();

    // Overlap: lowest index wins
    req(1, 22'h0b5, 2'b10, 0); settle();
    chk("overlap_sel", 32'(sel_out), 32'h4);
    advance();

    // IDLE keeps owner port 3
    req(1, 22'h0c0, 2'b10, 1); settle(); advance();
    req(1, 22'h010, 2'b00, 1); settle();
    chk("idle_keep_sel", 32'(sel_out), 32'h8);
    advance();

    // Back-to-back unmapped accesses saturate the counter
    for (int k = 0; k < 600; k++) begin
      req(1, 22'h3fffff, 2'b11, model_ready()); settle(); advance();
    end
    chk("sat_cnt", 32'(unmapped_cnt), 32'hff);
    if (m_ph == 1) begin
      req(1, 22'h3fffff, 2'b11, 0); settle(); advance();
    end
    cnt_clr = 1'b1; req(1, 22'h3fffff, 2'b10, 1); settle(); advance();
    cnt_clr = 1'b0; req(1, 22'h3fffff, 2'b00, 0); settle();
    chk("clr_prio_cnt", 32'(unmapped_cnt), 32'd0);
    chk("clr_prio_err", 32'(HREADYOUTS), 32'd0);
    advance(); req(1, 22'h3fffff, 2'b00, 1); settle(); advance();

    // Reset asserted while the error response is waiting
    req(1, 22'h3fffff, 2'b10, 1); settle(); advance();
    readyout_in = 4'b0001;
    req(1, 22'h3fffff, 2'b00, 0); settle();
    chk("pre_rst_err1", 32'(HREADYOUTS), 32'd0);
    HRESETn = 1'b0;
    model_reset();
    settle();
    chk("rst_mid_ready", 32'(HREADYOUTS), 32'd1);
    chk("rst_mid_cnt", 32'(unmapped_cnt), 32'd0);
    advance();
    HRESETn = 1'b1;

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      sel_dec = ($urandom_range(0, 7) != 0);
      decode_addr_dec = ($urandom_range(0, 3) == 0) ? 22'($urandom) : 22'($urandom_range(0, 'h11f));
      trans_dec = 2'($urandom);
      HREADYS = ($urandom_range(0, 3) != 0);
      remap = 1'($urandom);
      cnt_clr = ($urandom_range(0, 49) == 0);
      active_in = N'($urandom);
      readyout_in = N'($urandom);
      resp_in = (2*N)'($urandom);
      for (int i = 0; i < N; i++) begin
        rdata_in[32*i +: 32] = $urandom;
        ruser_in[32*i +: 32] = $urandom;
      end
      settle();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
